// File: rtl/lcs_answer_sched.sv
// ============================================================================
//  Module   : lcs_answer_sched
//  Purpose  : Per-frame word sequencer for the LCS answer path: req handshake,
//             word address stepping, serializer load and temperature rotation.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lcs_answer_sched #(
  parameter int WORDS    = 124,
  parameter int REQ_HIGH = 4,
  parameter int REQ_LOW  = 4,
  parameter int SEL_NUM  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       en_i,
  input  logic       txBusy_i,
  output logic       req_o,
  output logic [8:0] addrLCS_o,
  output logic [2:0] sel_o,
  output logic       txLoad_o,
  output logic       active_o,
  output logic       frameDone_o,
  output logic       overrun_o
);

  localparam int CNT_MAX = (REQ_HIGH > REQ_LOW) ? REQ_HIGH : REQ_LOW;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAITTX = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    addr_q, addr_d;
  logic [2:0]    sel_q, sel_d;
  logic          req_q, req_d;
  logic          txLoad_q, txLoad_d;
  logic          active_q, active_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      sel_q    <= '0;
      req_q    <= 1'b0;
      txLoad_q <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      req_q    <= req_d;
      txLoad_q <= txLoad_d;
      active_q <= active_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    req_d    = req_q;
    active_d = active_q;
    txLoad_d = 1'b0;
    done_d   = 1'b0;
    // Any start outside IDLE is dropped and flagged, regardless of en.
    ovr_d    = start_i && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (start_i && en_i) begin
          state_d  = REQ;
          active_d = 1'b1;
          addr_d   = '0;
          req_d    = 1'b1;
          cnt_d    = CW'(REQ_HIGH - 1);
        end
      end
      REQ: begin
        if (cnt_q == '0) begin
          req_d   = 1'b0;
          state_d = WAITTX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WAITTX: begin
        if (!txBusy_i) begin
          txLoad_d = 1'b1;
          state_d  = GAP;
          cnt_d    = CW'(REQ_LOW);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (addr_q == 9'(WORDS - 1)) begin
            state_d  = IDLE;
            active_d = 1'b0;
            done_d   = 1'b1;
            sel_d    = (sel_q == 3'(SEL_NUM - 1)) ? 3'd0 : sel_q + 3'd1;
          end else begin
            state_d = REQ;
            addr_d  = addr_q + 9'd1;
            req_d   = 1'b1;
            cnt_d   = CW'(REQ_HIGH - 1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_o       = req_q;
  assign addrLCS_o   = addr_q;
  assign sel_o       = sel_q;
  assign txLoad_o    = txLoad_q;
  assign active_o    = active_q;
  assign frameDone_o = done_q;
  assign overrun_o   = ovr_q;

endmodule

`default_nettype wire
